// File: rtl/uart_gpio_bridge.sv
// UART-to-GPIO bridge: 8N1 receiver, write/read command decoder over NUM_CH
// byte ports, two-entry reply FIFO and 8N1 transmitter.
module uart_gpio_bridge #(
  parameter int CLK_HZ       = 25000000,
  parameter int BAUD         = 115200,
  parameter int NUM_CH       = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic                  txd,
  output logic [8*NUM_CH-1:0]   gp_out,
  output logic [NUM_CH-1:0]     gp_out_strobe,
  input  logic [8*NUM_CH-1:0]   gp_in,
  output logic                  frame_err,
  output logic                  overrun
);
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int TO_CYC = TIMEOUT_BITS * CPB;
  localparam int CW     = $clog2(CPB + 1);
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [7:0] NCH = 8'(NUM_CH);

  // ---------------- RX ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;
  rx_st_t rs, rs_nx;
  logic rx_s1, rx_s2;
  logic [CW-1:0] rcnt;
  logic [2:0] rbit;
  logic [7:0] rsh;
  logic rtick_half, rtick, rx_valid, rx_ferr;

  assign rtick_half = (rcnt == CW'(HALF - 1));
  assign rtick      = (rcnt == CW'(CPB - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rs    <= R_IDLE;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rs    <= rs_nx;
    end

  always_comb begin
    rs_nx = rs;
    case (rs)
      R_IDLE:  if (!rx_s2) rs_nx = R_START;
      R_START: if (rtick_half) rs_nx = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rtick && rbit == 3'd7) rs_nx = R_STOP;
      R_STOP:  if (rtick) rs_nx = rx_s2 ? R_IDLE : R_WAIT;
      R_WAIT:  if (rx_s2) rs_nx = R_IDLE;
      default: rs_nx = R_IDLE;
    endcase
  end

  always_comb begin
    rx_valid = (rs == R_STOP) && rtick && rx_s2;
    rx_ferr  = (rs == R_STOP) && rtick && !rx_s2;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rcnt      <= '0;
      rbit      <= '0;
      rsh       <= '0;
      frame_err <= 1'b0;
    end else begin
      if (rs == R_IDLE || rs == R_WAIT || rs != rs_nx || (rs == R_DATA && rtick)) rcnt <= '0;
      else rcnt <= rcnt + CW'(1);
      if (rs == R_START) rbit <= '0;
      else if (rs == R_DATA && rtick) rbit <= rbit + 3'd1;
      if (rs == R_DATA && rtick) rsh <= {rx_s2, rsh[7:1]};
      if (rx_ferr) frame_err <= 1'b1;
    end

  // ---------------- protocol ----------------
  typedef enum logic {P_IDLE, P_DATA} p_st_t;
  p_st_t ps, ps_nx;
  logic [6:0] pch, ch_sel;
  logic [TW-1:0] tcnt;
  logic ch_ok, wr, push;
  logic [7:0] rd_byte, push_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) ps <= P_IDLE;
    else     ps <= ps_nx;

  always_comb begin
    ps_nx = ps;
    case (ps)
      P_IDLE:  if (rx_valid && rsh[7]) ps_nx = P_DATA;
      P_DATA:  if (rx_valid || tcnt == TW'(TO_CYC - 1)) ps_nx = P_IDLE;
      default: ps_nx = P_IDLE;
    endcase
  end

  always_comb begin
    ch_sel    = (ps == P_IDLE) ? rsh[6:0] : pch;
    ch_ok     = ({1'b0, ch_sel} < NCH);
    rd_byte   = 8'hFF;
    for (int k = 0; k < NUM_CH; k++)
      if (ch_sel == 7'(k)) rd_byte = gp_in[8*k +: 8];
    push      = 1'b0;
    wr        = 1'b0;
    push_data = 8'hFF;
    if (rx_valid) begin
      if (ps == P_IDLE && !rsh[7]) begin
        push      = 1'b1;
        push_data = rd_byte;
      end else if (ps == P_DATA) begin
        push      = 1'b1;
        wr        = ch_ok;
        push_data = ch_ok ? rsh : 8'hFF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pch           <= '0;
      tcnt          <= '0;
      gp_out        <= '0;
      gp_out_strobe <= '0;
    end else begin
      if (ps == P_IDLE && rx_valid && rsh[7]) pch <= rsh[6:0];
      tcnt <= (ps == P_DATA) ? tcnt + TW'(1) : '0;
      for (int k = 0; k < NUM_CH; k++) begin
        gp_out_strobe[k] <= wr && (pch == 7'(k));
        if (wr && pch == 7'(k)) gp_out[8*k +: 8] <= rsh;
      end
    end

  // ---------------- reply FIFO ----------------
  logic [7:0] fmem [2];
  logic fwp, frp, pop, do_push;
  logic [1:0] fcnt;

  // A full FIFO still accepts a push when the TX side pops in the same cycle.
  assign do_push = push && (fcnt != 2'd2 || pop);

  always_ff @(posedge clk)
    if (do_push) fmem[fwp] <= push_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fwp     <= 1'b0;
      frp     <= 1'b0;
      fcnt    <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) fwp <= ~fwp;
      if (pop) frp <= ~frp;
      fcnt <= fcnt + {1'b0, do_push} - {1'b0, pop};
      if (push && !do_push) overrun <= 1'b1;
    end

  // ---------------- TX ----------------
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
  tx_st_t ts, ts_nx;
  logic [CW-1:0] xcnt;
  logic [2:0] xbit;
  logic [7:0] xsh;
  logic xtick, fempty;

  assign xtick  = (xcnt == CW'(CPB - 1));
  assign fempty = (fcnt == 2'd0);

  always_ff @(posedge clk or posedge rst)
    if (rst) ts <= T_IDLE;
    else     ts <= ts_nx;

  always_comb begin
    ts_nx = ts;
    case (ts)
      T_IDLE:  if (!fempty) ts_nx = T_START;
      T_START: if (xtick) ts_nx = T_DATA;
      T_DATA:  if (xtick && xbit == 3'd7) ts_nx = T_STOP;
      T_STOP:  if (xtick) ts_nx = fempty ? T_IDLE : T_START;
      default: ts_nx = T_IDLE;
    endcase
  end

  // Popping at the end of a stop bit chains frames with no idle gap.
  always_comb pop = !fempty && (ts == T_IDLE || (ts == T_STOP && xtick));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      txd  <= 1'b1;
      xcnt <= '0;
      xbit <= '0;
      xsh  <= '0;
    end else begin
      xcnt <= (ts == T_IDLE || xtick) ? '0 : xcnt + CW'(1);
      if (pop) begin
        xsh <= fmem[frp];
        txd <= 1'b0;
      end else if (ts == T_START && xtick) begin
        txd  <= xsh[0];
        xbit <= '0;
      end else if (ts == T_DATA && xtick) begin
        if (xbit == 3'd7) txd <= 1'b1;
        else begin
          txd <= xsh[1];
          xsh <= {1'b0, xsh[7:1]};
        end
        xbit <= xbit + 3'd1;
      end
    end

endmodule

// File: tb/tb_uart_gpio_bridge.sv
// Scoreboard bench for uart_gpio_bridge: stimulus pushes expected replies and
// writes into queues, independent monitors decode txd and watch the strobes.
module tb_uart_gpio_bridge;
  localparam int CPB = 10;
  localparam int NB  = 53;

  logic        clk = 1'b0;
  logic        rst, rxd, txd, frame_err, overrun;
  logic [31:0] gp_out, gp_in;
  logic [3:0]  gp_out_strobe;

  uart_gpio_bridge #(.CLK_HZ(1000000), .BAUD(100000), .NUM_CH(4), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .gp_out(gp_out),
    .gp_out_strobe(gp_out_strobe), .gp_in(gp_in), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] mask; logic [31:0] val; } wr_t;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  txq[$];
  wr_t         wrq[$];
  logic [7:0]  gpo_m [4];
  bit          tx_abort = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_out();
    return {gpo_m[3], gpo_m[2], gpo_m[1], gpo_m[0]};
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int k);
    int i;
    i = k / CPB;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    return stop;
  endfunction

  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    for (int k = 0; k < 10*CPB; k++) begin
      @(negedge clk);
      rxd = frame_bit(b, stop, k);
    end
    @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic read_cmd(input logic [6:0] ch);
    txq.push_back(ch < 4 ? gp_in[8*ch +: 8] : 8'hFF);
    send({1'b0, ch});
  endtask

  task automatic write_cmd(input logic [6:0] ch, input logic [7:0] d);
    wr_t w;
    send({1'b1, ch});
    if (ch < 4) begin
      gpo_m[ch] = d;
      w.mask = 4'b0001 << ch;
      w.val  = model_out();
      wrq.push_back(w);
      txq.push_back(d);
    end else txq.push_back(8'hFF);
    send(d);
  endtask

  // TX monitor: decode every frame at mid-bit and compare with the reply queue.
  initial forever begin
    logic [7:0] b;
    logic st, sp;
    @(negedge clk);
    if (txd === 1'b0) begin
      repeat (CPB/2) @(negedge clk);
      st = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      sp = txd;
      if (!tx_abort) begin
        chk("tx_start_bit", st, 1'b0);
        chk("tx_stop_bit", sp, 1'b1);
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %h expected no frame", b);
        end else chk("tx_byte", b, txq.pop_front());
      end
    end
  end

  // Strobe monitor: every strobe cycle must match one queued write.
  initial forever begin
    wr_t w;
    @(negedge clk);
    if (gp_out_strobe !== 4'b0) begin
      if (wrq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: got %b expected none", gp_out_strobe);
      end else begin
        w = wrq.pop_front();
        chk("strobe_mask", gp_out_strobe, w.mask);
        chk("gp_out_on_write", gp_out, w.val);
      end
    end
  end

  initial begin
    logic [7:0] exp_b [$];
    logic [7:0] mq [$];
    int         mpush [$];
    int         tx_end, pt, t, first_drop;

    rxd = 1'b1;
    gp_in = '0;
    for (int i = 0; i < 4; i++) gpo_m[i] = 8'h00;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      repeat (20) @(negedge clk);
      chk("idle_txd", txd, 1'b1);
      chk("idle_gp_out", gp_out, 32'h0);
      chk("idle_flags", {frame_err, overrun}, 2'b00);
    end

    write_cmd(7'd2, 8'h5A);
    repeat (5) @(negedge clk);
    chk("ch2_value", gp_out[23:16], 8'h5A);

    gp_in = 32'h44332211;
    read_cmd(7'd3);
    read_cmd(7'd7);

    // A write command left without its data byte must expire silently.
    send(8'h81);
    repeat (250) @(negedge clk);
    read_cmd(7'd1);
    repeat (20) @(negedge clk);
    chk("timeout_no_write", gp_out[15:8], 8'h00);

    send(8'h81, 1'b0);
    repeat (20) @(negedge clk);
    chk("frame_err_set", frame_err, 1'b1);
    read_cmd(7'd0);

    for (int i = 0; i < 16; i++) begin
      logic [6:0] ch;
      gp_in = $urandom;
      ch = 7'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) write_cmd(ch, 8'($urandom));
      else read_cmd(ch);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    for (int i = 0; i < 4000 && (txq.size() != 0 || wrq.size() != 0); i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("drain_tx", txq.size(), 0);
    chk("drain_wr", wrq.size(), 0);
    chk("gp_out_final", gp_out, model_out());
    chk("no_overrun_yet", overrun, 1'b0);

    // Burst of reads with a 6-cycle stop bit: one request per 96 cycles in,
    // one reply per 100 cycles out. Model the FIFO with push/pop event times.
    gp_in = 32'hC3B2A190;
    tx_end = -1000;
    first_drop = -1;
    for (int n = 0; n < NB; n++) begin
      t = 96 * n;
      while (mq.size() > 0) begin
        pt = (tx_end > mpush[0] + 1) ? tx_end : mpush[0] + 1;
        if (pt > t) break;
        void'(mq.pop_front());
        void'(mpush.pop_front());
        tx_end = pt + 10*CPB;
      end
      if (mq.size() >= 2) begin
        if (first_drop < 0) first_drop = n;
      end else begin
        mq.push_back(gp_in[8*(n%4) +: 8]);
        mpush.push_back(t);
        exp_b.push_back(gp_in[8*(n%4) +: 8]);
      end
    end
    foreach (exp_b[i]) txq.push_back(exp_b[i]);

    for (int n = 0; n < NB; n++) begin
      for (int k = 0; k < 96; k++) begin
        @(negedge clk);
        rxd = frame_bit(8'(n % 4), 1'b1, k);
        if (k == 40 && n > 0)
          chk("overrun_timing", overrun, (first_drop >= 0 && first_drop < n));
      end
    end
    @(negedge clk);
    rxd = 1'b1;

    for (int i = 0; i < 200 && txd !== 1'b0; i++) @(negedge clk);
    chk("tx_busy_before_rst", txd, 1'b0);
    tx_abort = 1;
    rst = 1'b1;
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_gp_out", gp_out, 32'h0);
    txq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("post_rst_txd", txd, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
